bsg_div_seq: RTL and testbench
==============================

# bsg_div_seq

Sequential iterative integer divider, the inverse companion of `bsg_mul`. It accepts one `width_p`-bit dividend/divisor pair per transaction, signed or unsigned, and produces quotient and remainder after a fixed number of cycles. It uses a restoring shift-subtract datapath that retires one quotient bit per cycle. The block sits beside `bsg_mul` in `bsg_misc` behind a valid/ready input and valid/yumi output interface, so it can be dropped into an ALU or a coprocessor pipeline.

## Interface
- `width_p`, default 64: operand and result width in bits; must be at least 2.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `reset_i`  in  1  reset, asynchronous and active-high.
- `v_i`  in  1  request valid.
- `ready_o`  out  1  block can accept a request; a transfer occurs when `v_i & ready_o`.
- `dividend_i`  in  `width_p`  dividend; sampled only on the transfer cycle.
- `divisor_i`  in  `width_p`  divisor; sampled only on the transfer cycle.
- `signed_i`  in  1  1 selects two's-complement operands, 0 selects unsigned; sampled only on the transfer cycle.
- `v_o`  out  1  result valid.
- `quotient_o`  out  `width_p`  quotient.
- `remainder_o`  out  `width_p`  remainder.
- `yumi_i`  in  1  consumer takes the result; legal only when `v_o` is 1.

## Operation
- The FSM has four states: IDLE, CALC, FIXUP and DONE.
- **IDLE**
  - `ready_o` = 1.
  - On a transfer, the block latches the operand magnitudes, the quotient sign (`sign(x) ^ sign(y)`), the remainder sign (`sign(x)`), the original dividend and a zero-divisor flag.
  - It then loads the iteration counter with `width_p-1` and goes to CALC.
  - In unsigned mode, both signs are treated as 0.
- **CALC**, one iteration per cycle:
  - Shift the {partial remainder, dividend} register left by 1.
  - Trial-subtract the divisor magnitude, using a `width_p+1`-bit subtract.
  - If the result is non-negative, keep the difference and shift in quotient bit 1; otherwise shift in 0.
  - Leave CALC for FIXUP when the counter reaches 0.
- **FIXUP**, one cycle:
  - Negate the quotient if the quotient sign is set.
  - Negate the remainder if the remainder sign is set.
  - Go to DONE.
- **DONE**
  - `v_o` = 1. The outputs stay stable until `yumi_i`; on `yumi_i` the block goes to IDLE.
- **Divide by zero:** quotient = all ones, remainder = original `dividend_i`, in both modes. The sign fixup is suppressed.
- **Signed overflow** (most-negative value divided by -1): quotient = most-negative value, remainder = 0.
- **Remainder sign:** the remainder carries the sign of the dividend (truncating division). `|remainder| < |divisor|`.
- Asserting `yumi_i` outside DONE is ignored. `v_i` outside IDLE is ignored and no request is queued.

## Timing
- Reset values:
  - State = IDLE, `v_o` = 0, `quotient_o` = 0, `remainder_o` = 0.
  - `ready_o` = 0 while `reset_i` is high and 1 in the first cycle after deassertion.
- Latency: with a transfer on cycle T, `v_o` rises on cycle T+`width_p`+2. For `width_p` = 64 that is T+66.
- Throughput: after `yumi_i` on cycle U, `ready_o` = 1 on cycle U+1. There is no accept in the same cycle as `yumi_i`.
- `ready_o` and `v_o` are decoded from the state register only, with no combinational path from `v_i` or `yumi_i`.
- Reset asserted mid-CALC, FIXUP or DONE aborts the operation immediately and the result is discarded.

## Configuration
- `BSG_DIV_SEQ_ZERO_BYPASS_EN`
  - **Defined:** a zero divisor is detected on the transfer cycle and the block goes directly from IDLE to DONE. `v_o` rises on T+1 with the divide-by-zero result.
  - **Undefined:** a zero divisor runs the full CALC/FIXUP sequence with latency `width_p`+2, and the result is forced to the divide-by-zero values in FIXUP.
  - The result values are identical in both builds; only the latency differs.

## Test plan
- Unsigned 100 / 7, `width_p`=64: `v_o` at T+66, quotient 14, remainder 2.
- Signed -7 / 2: quotient -3 (0xFFFF_FFFF_FFFF_FFFD), remainder -1. Signed 7 / -2: quotient -3, remainder 1.
- Signed 0x8000_0000_0000_0000 / -1: quotient 0x8000_0000_0000_0000, remainder 0. The same operands unsigned give quotient 0, remainder 0x8000_0000_0000_0000.
- Divisor 0, dividend 0x1234, each mode: quotient all ones, remainder 0x1234. `v_o` at T+1 with `BSG_DIV_SEQ_ZERO_BYPASS_EN` defined, T+66 without.
- Backpressure: hold `yumi_i`=0 for 10 cycles in DONE and toggle `v_i` meanwhile. The outputs stay constant and no request is accepted. Assert `yumi_i`; `ready_o` rises the next cycle.
- Assert `reset_i` 20 cycles into CALC: `v_o`=0 immediately. After deassertion, a new 9 / 3 request returns quotient 3, remainder 0.

Source files
------------

// File: rtl/bsg_div_seq_if.sv
// Valid/ready request and valid/yumi result bundle for bsg_div_seq.
// The divider core is the slave side; the requester/consumer is the master side.
interface bsg_div_seq_if #(parameter int width_p = 64);
  logic               v_i;
  logic               ready_o;
  logic [width_p-1:0] dividend_i;
  logic [width_p-1:0] divisor_i;
  logic               signed_i;
  logic               v_o;
  logic [width_p-1:0] quotient_o;
  logic [width_p-1:0] remainder_o;
  logic               yumi_i;

  modport slave (
    input  v_i, dividend_i, divisor_i, signed_i, yumi_i,
    output ready_o, v_o, quotient_o, remainder_o
  );

  modport master (
    output v_i, dividend_i, divisor_i, signed_i, yumi_i,
    input  ready_o, v_o, quotient_o, remainder_o
  );
endinterface

// File: rtl/bsg_div_seq.sv
// Sequential restoring divider, one quotient bit per cycle, signed or unsigned.
// Optional macro BSG_DIV_SEQ_ZERO_BYPASS_EN: a zero divisor skips straight to DONE.
module bsg_div_seq #(parameter int width_p = 64) (
  input  logic         clk_i,
  input  logic         reset_i,
  bsg_div_seq_if.slave bus
);
  localparam int cnt_w = (width_p > 2) ? $clog2(width_p) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_e;

  state_e             state, state_n;
  logic [width_p-1:0] rem, quo, dvs, dividend_orig;
  logic               q_neg, r_neg, zero;
  logic [cnt_w-1:0]   cnt;

  logic               take;
  logic               dividend_neg, divisor_neg;
  logic [width_p-1:0] dividend_mag, divisor_mag;
  logic [width_p:0]   shifted, diff;

  always_comb begin
    take         = bus.v_i && (state == IDLE);
    dividend_neg = bus.signed_i & bus.dividend_i[width_p-1];
    divisor_neg  = bus.signed_i & bus.divisor_i[width_p-1];
    dividend_mag = dividend_neg ? -bus.dividend_i : bus.dividend_i;
    divisor_mag  = divisor_neg  ? -bus.divisor_i  : bus.divisor_i;
    // Sign bit of this (width_p+1)-bit difference says whether the trial subtract went negative
    shifted      = {rem, quo[width_p-1]};
    diff         = shifted - {1'b0, dvs};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (take) begin
`ifdef BSG_DIV_SEQ_ZERO_BYPASS_EN
          state_n = (bus.divisor_i == '0) ? DONE : CALC;
`else
          state_n = CALC;
`endif
        end
      end
      CALC:    if (cnt == '0) state_n = FIXUP;
      FIXUP:   state_n = DONE;
      DONE:    if (bus.yumi_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.ready_o     = (state == IDLE) && !reset_i;
  assign bus.v_o         = (state == DONE);
  assign bus.quotient_o  = quo;
  assign bus.remainder_o = rem;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rem           <= '0;
      quo           <= '0;
      dvs           <= '0;
      dividend_orig <= '0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      zero          <= 1'b0;
      cnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            dvs           <= divisor_mag;
            quo           <= dividend_mag;
            rem           <= '0;
            dividend_orig <= bus.dividend_i;
            q_neg         <= dividend_neg ^ divisor_neg;
            r_neg         <= dividend_neg;
            zero          <= (bus.divisor_i == '0);
            cnt           <= cnt_w'(width_p - 1);
`ifdef BSG_DIV_SEQ_ZERO_BYPASS_EN
            if (bus.divisor_i == '0) begin
              quo <= '1;
              rem <= bus.dividend_i;
            end
`endif
          end
        end
        CALC: begin
          rem <= diff[width_p] ? shifted[width_p-1:0] : diff[width_p-1:0];
          quo <= {quo[width_p-2:0], ~diff[width_p]};
          cnt <= cnt - 1'b1;
        end
        FIXUP: begin
          // Divide-by-zero result ignores the sign fixup entirely
          if (zero) begin
            quo <= '1;
            rem <= dividend_orig;
          end else begin
            if (q_neg) quo <= -quo;
            if (r_neg) rem <= -rem;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bsg_div_seq.sv
// Self-checking bench for bsg_div_seq: directed corner cases plus random operands
// compared against plain-arithmetic truncating division.
module tb_bsg_div_seq;
  localparam int W = 64;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bsg_div_seq_if #(.width_p(W)) bus ();

  bsg_div_seq #(.width_p(W)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Truncating division reference; corner cases handled before native operators
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (s && a == MIN_NEG && b == '1) begin
      q = MIN_NEG;
      r = '0;
    end else if (s) begin
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic apply_stimulus(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s, input int hold);
    logic [W-1:0] eq, er;
    int lat, exp_lat;
    ref_div(a, b, s, eq, er);
    exp_lat = W + 2;
`ifdef BSG_DIV_SEQ_ZERO_BYPASS_EN
    if (b == '0) exp_lat = 1;
`endif
    @(negedge clk);
    check_output({tag, ".ready"}, 64'(bus.ready_o), 64'd1);
    bus.v_i        = 1'b1;
    bus.dividend_i = a;
    bus.divisor_i  = b;
    bus.signed_i   = s;
    @(negedge clk);
    bus.v_i        = 1'b0;
    bus.dividend_i = {$urandom, $urandom};
    bus.divisor_i  = {$urandom, $urandom};
    lat = 1;
    while (!bus.v_o && lat < 4 * W) begin
      @(negedge clk);
      lat++;
    end
    check_output({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check_output({tag, ".quotient"}, bus.quotient_o, eq);
    check_output({tag, ".remainder"}, bus.remainder_o, er);
    for (int i = 0; i < hold; i++) begin
      bus.v_i        = i[0];
      bus.dividend_i = {$urandom, $urandom};
      bus.divisor_i  = 64'($urandom_range(1, 50));
      @(negedge clk);
      check_output({tag, ".hold_v"}, 64'(bus.v_o), 64'd1);
      check_output({tag, ".hold_ready"}, 64'(bus.ready_o), 64'd0);
      check_output({tag, ".hold_q"}, bus.quotient_o, eq);
      check_output({tag, ".hold_r"}, bus.remainder_o, er);
    end
    bus.v_i    = 1'b0;
    bus.yumi_i = 1'b1;
    @(negedge clk);
    bus.yumi_i = 1'b0;
    check_output({tag, ".ready_after_yumi"}, 64'(bus.ready_o), 64'd1);
    check_output({tag, ".v_after_yumi"}, 64'(bus.v_o), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    int           lat;
    bus.v_i        = 1'b0;
    bus.yumi_i     = 1'b0;
    bus.dividend_i = '0;
    bus.divisor_i  = '0;
    bus.signed_i   = 1'b0;

    // Reset state
    #12;
    check_output("reset.ready", 64'(bus.ready_o), 64'd0);
    check_output("reset.v", 64'(bus.v_o), 64'd0);
    check_output("reset.q", bus.quotient_o, 64'd0);
    check_output("reset.r", bus.remainder_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("reset.ready_release", 64'(bus.ready_o), 64'd1);

    // Directed cases
    apply_stimulus("u100_7", 64'd100, 64'd7, 1'b0, 0);
    apply_stimulus("s-7_2", -64'sd7, 64'd2, 1'b1, 0);
    apply_stimulus("s7_-2", 64'd7, -64'sd2, 1'b1, 0);
    apply_stimulus("s_min_-1", MIN_NEG, '1, 1'b1, 0);
    apply_stimulus("u_min_ones", MIN_NEG, '1, 1'b0, 0);
    apply_stimulus("u_div0", 64'h1234, 64'd0, 1'b0, 0);
    apply_stimulus("s_div0", 64'h1234, 64'd0, 1'b1, 0);
    apply_stimulus("s_div0_neg", -64'sd5, 64'd0, 1'b1, 0);
    apply_stimulus("backpressure", 64'd1000, 64'd33, 1'b0, 10);

    // No request may have been queued during backpressure
    repeat (5) @(negedge clk);
    check_output("noqueue.v", 64'(bus.v_o), 64'd0);
    check_output("noqueue.ready", 64'(bus.ready_o), 64'd1);

    // Reset mid-CALC
    @(negedge clk);
    bus.v_i        = 1'b1;
    bus.dividend_i = 64'd12345;
    bus.divisor_i  = 64'd7;
    bus.signed_i   = 1'b0;
    @(negedge clk);
    bus.v_i = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("midreset.v", 64'(bus.v_o), 64'd0);
    check_output("midreset.ready", 64'(bus.ready_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("midreset.ready_release", 64'(bus.ready_o), 64'd1);
    check_output("midreset.q", bus.quotient_o, 64'd0);
    lat = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (bus.v_o) lat++;
    end
    check_output("midreset.no_stale_v", 64'(lat), 64'd0);
    apply_stimulus("u9_3", 64'd9, 64'd3, 1'b0, 0);

    // Random operands over a mix of divisor magnitudes and signs
    for (int n = 0; n < 24; n++) begin
      ra = {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       rb = {$urandom, $urandom};
        1:       rb = 64'($urandom_range(1, 1000));
        2:       rb = {$urandom, $urandom} >> $urandom_range(1, 62);
        default: rb = -64'($urandom_range(1, 1000));
      endcase
      if (rb == '0) rb = 64'd3;
      if (n % 5 == 4) ra = ra >> $urandom_range(8, 60);
      apply_stimulus($sformatf("rand%0d", n), ra, rb, rs, 0);
    end

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
